// File: rtl/vdu_buf_arbiter.sv
// Time-slot arbiter sharing the VDU text buffer RAM port between the Wishbone
// CPU slave and the display character fetch; one slot phase belongs to the display.
module vdu_buf_arbiter #(
    parameter int                SLOT_W     = 3,
    parameter logic [SLOT_W-1:0] DISP_PHASE = 3'd1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [10:0]       wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic [15:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [SLOT_W-1:0] slot_i,
    input  logic [10:0]       disp_addr_i,
    output logic [10:0]       ram_addr_o,
    output logic [15:0]       ram_wdata_o,
    output logic [1:0]        ram_we_o,
    input  logic [15:0]       ram_rdata_i,
    output logic [15:0]       disp_data_o,
    output logic              disp_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [10:0] adr_r;
    logic [15:0] dat_r;
    logic [1:0]  sel_r;
    logic        we_r;
    logic        disp_fetch_r;
    logic        req_s;
    logic        disp_slot_s;

    assign req_s       = wb_stb_i & wb_cyc_i;
    assign disp_slot_s = (slot_i == DISP_PHASE);

    // Next-state logic; an abandoned request leaves REQ before touching the RAM
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) state_s = REQ;
                else       state_s = IDLE;
            end
            REQ: begin
                if (!req_s)           state_s = IDLE;
                else if (disp_slot_s) state_s = REQ;
                else if (we_r)        state_s = ACK;
                else                  state_s = RD;
            end
            RD:      state_s = ACK;
            ACK:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // RAM port mux; the display phase is always a read
    always_comb begin
        ram_addr_o  = adr_r;
        ram_wdata_o = dat_r;
        ram_we_o    = 2'b00;
        if (disp_slot_s) begin
            ram_addr_o = disp_addr_i;
        end else begin
            ram_addr_o = adr_r;
        end
        if ((state_r == REQ) && req_s && we_r && !disp_slot_s) begin
            ram_we_o = sel_r;
        end else begin
            ram_we_o = 2'b00;
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_r <= IDLE;
        else          state_r <= state_s;
    end

    // Capture the CPU request when it is first seen in IDLE
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            adr_r <= 11'd0;
            dat_r <= 16'd0;
            sel_r <= 2'b00;
            we_r  <= 1'b0;
        end else if ((state_r == IDLE) && req_s) begin
            adr_r <= wb_adr_i;
            dat_r <= wb_dat_i;
            sel_r <= wb_sel_i;
            we_r  <= wb_we_i;
        end
    end

    // Wishbone ack and read data; ack is high exactly while the FSM sits in ACK
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 16'd0;
        end else begin
            wb_ack_o <= (state_s == ACK);
            if (state_r == RD) wb_dat_o <= ram_rdata_i;
        end
    end

    // Display fetch pipeline: flag the reserved phase, then latch the RAM word
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            disp_fetch_r <= 1'b0;
            disp_data_o  <= 16'd0;
            disp_valid_o <= 1'b0;
        end else begin
            disp_fetch_r <= disp_slot_s;
            disp_valid_o <= disp_fetch_r;
            if (disp_fetch_r) disp_data_o <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_vdu_buf_arbiter.sv
// Directed self-checking bench for vdu_buf_arbiter with a behavioural
// synchronous byte-lane RAM and a free-running slot counter.
module tb_vdu_buf_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [10:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic [2:0]  slot_i = 3'd0;
    logic [10:0] disp_addr_i;
    logic [10:0] ram_addr_o;
    logic [15:0] ram_wdata_o;
    logic [1:0]  ram_we_o;
    logic [15:0] ram_rdata_i = 16'h0000;
    logic [15:0] disp_data_o;
    logic        disp_valid_o;

    logic [15:0] mem [0:2047];
    int total_cnt = 0;
    int bad_cnt   = 0;
    int pulses;

    vdu_buf_arbiter dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_we_i     (wb_we_i),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .slot_i      (slot_i),
        .disp_addr_i (disp_addr_i),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_we_o    (ram_we_o),
        .ram_rdata_i (ram_rdata_i),
        .disp_data_o (disp_data_o),
        .disp_valid_o(disp_valid_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Timing generator stand-in
    always @(posedge wb_clk_i) slot_i <= slot_i + 3'd1;

    // Synchronous RAM, read-before-write, per-byte enables
    always @(posedge wb_clk_i) begin
        ram_rdata_i <= mem[ram_addr_o];
        if (ram_we_o[0]) mem[ram_addr_o][7:0]  <= ram_wdata_o[7:0];
        if (ram_we_o[1]) mem[ram_addr_o][15:8] <= ram_wdata_o[15:8];
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic mid;
        @(negedge wb_clk_i);
    endtask

    task automatic wait_slot(input logic [2:0] v);
        int n;
        n = 0;
        tick;
        while (slot_i != v && n < 16) begin
            tick;
            n++;
        end
        check_val("wait_slot", 16'(slot_i), 16'(v));
    endtask

    task automatic wb_drive(input logic [10:0] a, input logic [15:0] d, input logic [1:0] s, input logic w);
        wb_adr_i = a;
        wb_dat_i = d;
        wb_sel_i = s;
        wb_we_i  = w;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
    endtask

    task automatic wb_idle;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[11'h7CF] = 16'h0741;
        mem[11'h006] = 16'h1111;
        mem[11'h123] = 16'h5A3C;
        mem[11'h010] = 16'h2222;
        mem[11'h020] = 16'h3333;
        disp_addr_i = 11'h7CF;
        wb_rst_i = 1'b1;
        wb_drive(11'h005, 16'hFFFF, 2'b11, 1'b1);

        // Reset held with a live strobe and the slot cycling
        for (int i = 0; i < 10; i++) begin
            tick;
            mid;
            check_val("rst_ack",   16'(wb_ack_o),     16'h0);
            check_val("rst_dat",   wb_dat_o,          16'h0000);
            check_val("rst_valid", 16'(disp_valid_o), 16'h0);
            check_val("rst_we",    16'(ram_we_o),     16'h0);
        end
        tick;
        wb_rst_i = 1'b0;
        wb_idle;
        mid;
        check_val("post_rst_ack", 16'(wb_ack_o), 16'h0);
        for (int i = 0; i < 2; i++) begin
            tick;
            mid;
            check_val("post_rst_ack", 16'(wb_ack_o), 16'h0);
        end

        // Full-word write, REQ on phase 3
        wait_slot(3'd2);
        wb_drive(11'h005, 16'h1E41, 2'b11, 1'b1);
        mid;
        check_val("w1_s_we", 16'(ram_we_o), 16'h0);
        tick;
        mid;
        check_val("w1_we",    16'(ram_we_o),    16'h3);
        check_val("w1_addr",  16'(ram_addr_o),  16'h0005);
        check_val("w1_wdata", ram_wdata_o,      16'h1E41);
        check_val("w1_noack", 16'(wb_ack_o),    16'h0);
        tick;
        wb_idle;
        mid;
        check_val("w1_ack", 16'(wb_ack_o), 16'h1);
        check_val("w1_we2", 16'(ram_we_o), 16'h0);
        tick;
        mid;
        check_val("w1_ack_off", 16'(wb_ack_o), 16'h0);
        check_val("w1_mem",     mem[11'h005],  16'h1E41);

        // Attribute-only write
        wait_slot(3'd2);
        wb_drive(11'h006, 16'hAB12, 2'b10, 1'b1);
        tick;
        mid;
        check_val("w2_we", 16'(ram_we_o), 16'h2);
        tick;
        wb_idle;
        mid;
        check_val("w2_ack", 16'(wb_ack_o), 16'h1);
        tick;
        mid;
        check_val("w2_mem", mem[11'h006], 16'hAB11);

        // Best-case read, ack at S+3
        wait_slot(3'd3);
        wb_drive(11'h005, 16'h0000, 2'b11, 1'b0);
        tick;
        mid;
        check_val("r1_addr", 16'(ram_addr_o), 16'h0005);
        check_val("r1_we",   16'(ram_we_o),   16'h0);
        tick;
        mid;
        check_val("r1_rd_noack", 16'(wb_ack_o), 16'h0);
        tick;
        wb_idle;
        mid;
        check_val("r1_ack", 16'(wb_ack_o), 16'h1);
        check_val("r1_dat", wb_dat_o,      16'h1E41);

        // Read colliding with the display phase, ack at S+4
        wait_slot(3'd0);
        wb_drive(11'h123, 16'h0000, 2'b11, 1'b0);
        tick;
        mid;
        check_val("r2_disp_addr", 16'(ram_addr_o), 16'h07CF);
        check_val("r2_disp_we",   16'(ram_we_o),   16'h0);
        check_val("r2_noack1",    16'(wb_ack_o),   16'h0);
        tick;
        mid;
        check_val("r2_cpu_addr", 16'(ram_addr_o), 16'h0123);
        check_val("r2_noack2",   16'(wb_ack_o),   16'h0);
        tick;
        mid;
        check_val("r2_noack3", 16'(wb_ack_o), 16'h0);
        tick;
        wb_idle;
        mid;
        check_val("r2_ack", 16'(wb_ack_o), 16'h1);
        check_val("r2_dat", wb_dat_o,      16'h5A3C);
        tick;
        mid;
        check_val("r2_ack_off",  16'(wb_ack_o), 16'h0);
        check_val("r2_dat_hold", wb_dat_o,      16'h5A3C);

        // Display fetch: pulse two cycles after the reserved phase, every 8 clocks
        wait_slot(3'd1);
        mid;
        tick;
        mid;
        check_val("d_t1_valid", 16'(disp_valid_o), 16'h0);
        tick;
        mid;
        check_val("d_t2_valid", 16'(disp_valid_o), 16'h1);
        check_val("d_t2_data",  disp_data_o,       16'h0741);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            mid;
            if (disp_valid_o) begin
                pulses++;
                check_val("d_rep_data", disp_data_o, 16'h0741);
                check_val("d_rep_slot", 16'(slot_i), 16'h3);
            end
        end
        check_val("d_rate", 16'(pulses), 16'h2);

        // Strobe dropped while stalled on the display phase
        wait_slot(3'd0);
        wb_drive(11'h010, 16'hFFFF, 2'b11, 1'b1);
        tick;
        wb_idle;
        mid;
        check_val("ab_we0", 16'(ram_we_o), 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick;
            mid;
            check_val("ab_ack", 16'(wb_ack_o), 16'h0);
            check_val("ab_we",  16'(ram_we_o), 16'h0);
        end
        check_val("ab_mem", mem[11'h010], 16'h2222);

        // Asynchronous reset in the REQ cycle of a write
        wait_slot(3'd2);
        wb_drive(11'h020, 16'h9999, 2'b11, 1'b1);
        tick;
        #1;
        check_val("ar_pre_we", 16'(ram_we_o), 16'h3);
        wb_rst_i = 1'b1;
        #1;
        check_val("ar_we",  16'(ram_we_o), 16'h0);
        check_val("ar_ack", 16'(wb_ack_o), 16'h0);
        check_val("ar_dat", wb_dat_o,      16'h0000);
        mid;
        check_val("ar_disp", disp_data_o, 16'h0000);
        tick;
        wb_rst_i = 1'b0;
        wb_idle;
        mid;
        check_val("ar_ack1", 16'(wb_ack_o), 16'h0);
        tick;
        mid;
        check_val("ar_ack2", 16'(wb_ack_o), 16'h0);
        check_val("ar_mem",  mem[11'h020],  16'h3333);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/vdu_buf_arbiter.md
# vdu_buf_arbiter

Time-slot arbiter for the VDU text buffer, the character and attribute RAM pair. It shares the single RAM port between the Wishbone CPU slave and the display character fetch. One phase of every character slot is reserved for the display; the CPU is served in any other phase. It produces registered Wishbone acks and read data, and a registered fetch result for the display pipeline.

## Interface
- SLOT_W, 3: width of the slot phase input; the slot lasts 2^SLOT_W clocks (one character cell).
- DISP_PHASE, 3'd1: slot phase reserved for the display fetch.
- wb_clk_i  in  1  VDU pixel clock; all logic on its rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wb_adr_i  in  11  word address into the 2K text buffer.
- wb_dat_i  in  16  write data: [15:8] attribute, [7:0] character.
- wb_sel_i  in  2  byte lanes: [1] attribute, [0] character.
- wb_we_i  in  1  write enable.
- wb_stb_i, wb_cyc_i  in  1 each  Wishbone strobe and cycle.
- wb_dat_o  out  16  registered read data.
- wb_ack_o  out  1  registered, single-cycle ack.
- slot_i  in  SLOT_W  current slot phase (h_count low bits from the timing generator).
- disp_addr_i  in  11  display fetch address, valid when slot_i==DISP_PHASE.
- ram_addr_o  out  11  RAM address (both RAMs).
- ram_wdata_o  out  16  RAM write data.
- ram_we_o  out  2  per-byte write enables, same lane order as wb_sel_i.
- ram_rdata_i  in  16  RAM read data; synchronous RAM, valid the cycle after the address.
- disp_data_o  out  16  registered fetch result {attr, char}.
- disp_valid_o  out  1  one-cycle pulse when disp_data_o updates.

## Operation
- FSM states: IDLE, REQ, RD, ACK. Reset state is IDLE.
- IDLE: if wb_stb_i&wb_cyc_i, capture adr, dat, sel and we into adr_q, dat_q, sel_q, we_q, then go to REQ.
- REQ, when slot_i!=DISP_PHASE: issue the CPU access.
  - Write: go to ACK.
  - Read: go to RD.
- REQ, when slot_i==DISP_PHASE: stay in REQ; the display owns the port.
- REQ, when stb or cyc is low: abort to IDLE. No RAM access, no ack.
- RD: wb_dat_o <= ram_rdata_i, then go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then go to IDLE.
  - wb_dat_o holds its value until the next read.
  - A write that was already issued completes even if stb has since dropped; its ack still pulses once and the master ignores it.
- Port mux (combinational from state and slot_i):
  - ram_addr_o = disp_addr_i when slot_i==DISP_PHASE, else adr_q.
  - ram_wdata_o = dat_q.
  - ram_we_o = sel_q only in REQ with we_q=1 and slot_i!=DISP_PHASE; otherwise 2'b00.
- The display phase always reads; ram_we_o is never nonzero when slot_i==DISP_PHASE.
- A write with sel=2'b00 goes through the normal sequence and is acked, with no RAM update.
- Display pipeline:
  - A flag registers slot_i==DISP_PHASE.
  - In the following cycle, disp_data_o <= ram_rdata_i and disp_valid_o pulses in the cycle after that.
  - disp_data_o holds between fetches.
- Reset values: wb_dat_o=0, wb_ack_o=0, disp_data_o=0, disp_valid_o=0, all captured registers 0, state IDLE.
- Asserting reset mid-operation forces IDLE immediately. ram_we_o goes to 0 combinationally in the same cycle, and no ack is issued for the aborted cycle.

## Timing
- Request first seen in IDLE at cycle S; REQ occupies S+1.
- Write: RAM write strobed in the first REQ cycle that is not the display phase; ack in the following cycle. Best case ack at S+2.
- Read: address issued in REQ, data captured in RD, ack with valid wb_dat_o in the cycle after RD. Best case ack at S+3.
- Each REQ cycle that coincides with DISP_PHASE adds exactly one cycle; at most one stall per access, since the reserved phase is a single cycle.
- Display: fetch at cycle T (slot_i==DISP_PHASE), RAM data during T+1, disp_valid_o=1 and disp_data_o valid at T+2. Exactly one pulse per slot.
- Back-to-back access: a new request may be captured in the IDLE cycle right after ACK. Peak rate is one write per 3 clocks and one read per 4 clocks.

## Test plan
- Reset with stb high and slot_i cycling: wb_ack_o=0, wb_dat_o=0, disp_valid_o=0 and ram_we_o=00 throughout reset; after release, the first ack appears only after a new capture.
- Write adr=0x005, dat=0x1E41, sel=11, captured with slot_i=2 so REQ falls on phase 3 (not DISP_PHASE): ram_we_o=11, ram_addr_o=0x005 and ram_wdata_o=0x1E41 at S+1; ack at S+2. Repeat with sel=10: ram_we_o=10.
- Read collision: capture at slot_i=0 so REQ hits DISP_PHASE. That cycle, ram_addr_o equals disp_addr_i and ram_we_o=00. The CPU address is issued on phase 2, and the ack arrives at S+4 with wb_dat_o equal to the RAM word.
- Display fetch with disp_addr_i=0x7CF and RAM returning 0x0741: disp_valid_o pulses once, 2 cycles after phase DISP_PHASE, with disp_data_o=0x0741; it repeats every 8 clocks.
- Drop stb while stalled in REQ on DISP_PHASE: no ram_we_o, no ack, FSM back in IDLE.
- Assert wb_rst_i asynchronously during the REQ cycle of a write: ram_we_o drops to 00 in the same cycle; after reset, RAM contents at that address are unchanged.
